// File: rtl/md_hilo_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Runs shift-add multiply or restoring divide, one radix-2 step per cycle, and stalls the CPU meanwhile.
module md_hilo_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       choice_md,
    input  logic [4:0]       choice_hilo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] mul_res
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_start;
    logic [1:0]       w_op;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_acc_hi_next;
    logic [WIDTH-1:0] w_acc_lo_next;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_unused;

    assign w_unused = choice_hilo[0];
    assign w_start  = (r_state == S_IDLE) && (choice_md != 4'd0);

    // Multi-hot decode resolves div > divu > mul > multu.
    always_comb begin
        w_op = OP_MULTU;
        if (choice_md[3])      w_op = OP_DIV;
        else if (choice_md[2]) w_op = OP_DIVU;
        else if (choice_md[1]) w_op = OP_MUL;
    end

    assign w_rs_neg = (w_op == OP_DIV) && rs_data[WIDTH-1];
    assign w_rt_neg = (w_op == OP_DIV) && rt_data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;

    // Multiply keeps {acc_hi, acc_lo} as the product with the multiplier shifting out of acc_lo;
    // divide keeps the partial remainder in acc_hi and shifts quotient bits into acc_lo.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    always_comb begin
        w_acc_hi_next = w_mul_sum[WIDTH:1];
        w_acc_lo_next = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        if (r_op[1]) begin
            if (!w_div_diff[WIDTH]) begin
                w_acc_hi_next = w_div_diff[WIDTH-1:0];
                w_acc_lo_next = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_hi_next = w_div_shift[WIDTH-1:0];
                w_acc_lo_next = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // With a zero divisor the remainder path leaves |rs|, so the dividend-sign fix restores rs exactly.
    assign w_quo_fix = r_dz ? {WIDTH{1'b1}} : ((r_sa ^ r_sb) ? -r_acc_lo : r_acc_lo);
    assign w_rem_fix = r_sa ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MULTU;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_ITER;
                        r_cnt    <= '0;
                        r_op     <= w_op;
                        r_sa     <= w_rs_neg;
                        r_sb     <= w_rt_neg;
                        r_dz     <= (rt_data == '0);
                        r_acc_hi <= '0;
                        if (w_op[1]) begin
                            r_opnd   <= w_rt_mag;
                            r_acc_lo <= w_rs_mag;
                        end else begin
                            r_opnd   <= rs_data;
                            r_acc_lo <= rt_data;
                        end
                    end else begin
                        if (choice_hilo[2]) r_hi <= rs_data;
                        if (choice_hilo[1]) r_lo <= rs_data;
                    end
                end
                S_ITER: begin
                    r_acc_hi <= w_acc_hi_next;
                    r_acc_lo <= w_acc_lo_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    case (r_op)
                        OP_MULTU: begin
                            r_hi <= r_acc_hi;
                            r_lo <= r_acc_lo;
                        end
                        OP_DIVU, OP_DIV: begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall      = !rst && (w_start || (r_state == S_ITER));
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIX);
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign hilo_rdata = choice_hilo[4] ? r_hi : (choice_hilo[3] ? r_lo : '0);
    assign mul_res    = (done && (r_op == OP_MUL)) ? r_acc_lo : '0;

endmodule

// File: tb/tb_md_hilo_seq.sv
// Directed testbench for md_hilo_seq: multiply/divide latency, results, HI/LO moves and reset abort.
module tb_md_hilo_seq;

    localparam logic [3:0] MD_DIV   = 4'b1000;
    localparam logic [3:0] MD_DIVU  = 4'b0100;
    localparam logic [3:0] MD_MUL   = 4'b0010;
    localparam logic [3:0] MD_MULTU = 4'b0001;
    localparam logic [4:0] HL_MFHI  = 5'b10000;
    localparam logic [4:0] HL_MFLO  = 5'b01000;
    localparam logic [4:0] HL_MTHI  = 5'b00100;
    localparam logic [4:0] HL_MTLO  = 5'b00010;
    localparam logic [4:0] HL_MD    = 5'b00001;
    localparam logic [4:0] HL_NONE  = 5'b00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  choice_md;
    logic [4:0]  choice_hilo;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;
    logic [31:0] mul_res;

    int n_checks = 0;
    int n_pass   = 0;

    md_hilo_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .choice_md   (choice_md),
        .choice_hilo (choice_hilo),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .hilo_rdata  (hilo_rdata),
        .mul_res     (mul_res)
    );

    always #5 clk = ~clk;

    // Issues one md instruction, holds it through the done cycle, then removes it after the retiring edge.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stall_cyc, output bit saw_done,
                          output logic stall_at_done, output logic [31:0] mres);
        @(posedge clk); #1;
        choice_md   = op;
        choice_hilo = HL_MD;
        rs_data     = a;
        rt_data     = b;
        stall_cyc     = 0;
        saw_done      = 1'b0;
        stall_at_done = 1'b1;
        mres          = 32'h0;
        for (int c = 0; c < 100 && !saw_done; c++) begin
            @(negedge clk);
            if (done) begin
                saw_done      = 1'b1;
                stall_at_done = stall;
                mres          = mul_res;
            end else if (stall) begin
                stall_cyc++;
            end
        end
        @(posedge clk); #1;
        choice_md   = 4'd0;
        choice_hilo = HL_NONE;
        $display("txn op=%b rs=%h rt=%h stall_cycles=%0d done=%0d mul_res=%h hi=%h lo=%h",
                 op, a, b, stall_cyc, saw_done, mres, hi, lo);
    endtask

    task automatic move_hilo(input logic [4:0] sel, input logic [31:0] a, output logic stall_seen);
        @(posedge clk); #1;
        choice_hilo = sel;
        rs_data     = a;
        @(negedge clk);
        stall_seen = stall;
        @(posedge clk); #1;
        choice_hilo = HL_NONE;
        $display("txn hilo_sel=%b rs=%h stall=%0d hi=%h lo=%h", sel, a, stall_seen, hi, lo);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        choice_md   = MD_MULTU;
        choice_hilo = HL_MFHI;
        rs_data     = 32'h1111_2222;
        rt_data     = 32'h3333_4444;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall actual=%b expected=0", stall); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy actual=%b expected=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done actual=%b expected=0", done); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL rst_hi actual=%h expected=00000000", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL rst_lo actual=%h expected=00000000", lo); else n_pass++;
        n_checks++; if (mul_res !== 32'h0) $display("FAIL rst_mul_res actual=%h expected=00000000", mul_res); else n_pass++;
        n_checks++; if (hilo_rdata !== 32'h0) $display("FAIL rst_hilo_rdata actual=%h expected=00000000", hilo_rdata); else n_pass++;
        @(posedge clk); #1;
        rst         = 1'b0;
        choice_md   = 4'd0;
        choice_hilo = HL_NONE;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL idle_stall actual=%b expected=0", stall); else n_pass++;
        $display("txn reset released busy=%b stall=%b", busy, stall);
    endtask

    task automatic test_multu();
        int sc; bit sd; logic sad; logic [31:0] mr;
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, sd, sad, mr);
        n_checks++; if (sd !== 1'b1) $display("FAIL multu_done actual=%b expected=1", sd); else n_pass++;
        n_checks++; if (sc != 33) $display("FAIL multu_stall_cycles actual=%0d expected=33", sc); else n_pass++;
        n_checks++; if (sad !== 1'b0) $display("FAIL multu_stall_in_fix actual=%b expected=0", sad); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL multu_no_restart actual=%b expected=0", busy); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi actual=%h expected=fffffffe", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo actual=%h expected=00000001", lo); else n_pass++;
        @(posedge clk); #1;
        choice_hilo = HL_MFLO;
        @(negedge clk);
        n_checks++; if (hilo_rdata !== 32'h0000_0001) $display("FAIL mflo_rdata actual=%h expected=00000001", hilo_rdata); else n_pass++;
        $display("txn mflo rdata=%h", hilo_rdata);
        @(posedge clk); #1;
        choice_hilo = HL_NONE;
    endtask

    task automatic test_div_signed();
        int sc; bit sd; logic sad; logic [31:0] mr;
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, sc, sd, sad, mr);
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_m7_2_lo actual=%h expected=fffffffd", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_m7_2_hi actual=%h expected=ffffffff", hi); else n_pass++;
        run_md(MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, sc, sd, sad, mr);
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_7_m2_lo actual=%h expected=fffffffd", lo); else n_pass++;
        n_checks++; if (hi !== 32'h0000_0001) $display("FAIL div_7_m2_hi actual=%h expected=00000001", hi); else n_pass++;
        n_checks++; if (sc != 33) $display("FAIL div_stall_cycles actual=%0d expected=33", sc); else n_pass++;
    endtask

    task automatic test_div_boundary();
        int sc; bit sd; logic sad; logic [31:0] mr;
        run_md(MD_DIVU, 32'h0000_0064, 32'h0, sc, sd, sad, mr);
        n_checks++; if (sc != 33) $display("FAIL divu_zero_stall_cycles actual=%0d expected=33", sc); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu_zero_lo actual=%h expected=ffffffff", lo); else n_pass++;
        n_checks++; if (hi !== 32'h0000_0064) $display("FAIL divu_zero_hi actual=%h expected=00000064", hi); else n_pass++;
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, sd, sad, mr);
        n_checks++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo actual=%h expected=80000000", lo); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL div_ovf_hi actual=%h expected=00000000", hi); else n_pass++;
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'h0, sc, sd, sad, mr);
        n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div_zero_lo actual=%h expected=ffffffff", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFF9) $display("FAIL div_zero_hi actual=%h expected=fffffff9", hi); else n_pass++;
    endtask

    task automatic test_mul();
        int sc; bit sd; logic sad; logic [31:0] mr; logic st;
        move_hilo(HL_MTHI, 32'hAAAA_5555, st);
        n_checks++; if (st !== 1'b0) $display("FAIL mthi_stall actual=%b expected=0", st); else n_pass++;
        move_hilo(HL_MTLO, 32'hAAAA_5555, st);
        n_checks++; if (lo !== 32'hAAAA_5555) $display("FAIL mtlo_lo actual=%h expected=aaaa5555", lo); else n_pass++;
        run_md(MD_MUL, 32'hFFFF_FFFD, 32'h0000_0005, sc, sd, sad, mr);
        n_checks++; if (mr !== 32'hFFFF_FFF1) $display("FAIL mul_res_done actual=%h expected=fffffff1", mr); else n_pass++;
        @(negedge clk);
        n_checks++; if (mul_res !== 32'h0) $display("FAIL mul_res_after actual=%h expected=00000000", mul_res); else n_pass++;
        n_checks++; if (hi !== 32'hAAAA_5555) $display("FAIL mul_hi_kept actual=%h expected=aaaa5555", hi); else n_pass++;
        n_checks++; if (lo !== 32'hAAAA_5555) $display("FAIL mul_lo_kept actual=%h expected=aaaa5555", lo); else n_pass++;
    endtask

    task automatic test_mthi_mfhi();
        logic st;
        move_hilo(HL_MTHI, 32'h0000_1234, st);
        n_checks++; if (st !== 1'b0) $display("FAIL mthi2_stall actual=%b expected=0", st); else n_pass++;
        choice_hilo = HL_MFHI;
        @(negedge clk);
        n_checks++; if (hilo_rdata !== 32'h0000_1234) $display("FAIL mfhi_rdata actual=%h expected=00001234", hilo_rdata); else n_pass++;
        $display("txn mfhi rdata=%h", hilo_rdata);
        @(posedge clk); #1;
        choice_hilo = HL_NONE;
        @(negedge clk);
        n_checks++; if (hilo_rdata !== 32'h0) $display("FAIL no_mf_rdata actual=%h expected=00000000", hilo_rdata); else n_pass++;
    endtask

    task automatic test_priority();
        int sc; bit sd; logic sad; logic [31:0] mr;
        // -100 / 7 signed gives q=-14 r=-2; any lower-priority op would give different HI/LO
        run_md(4'b1111, 32'hFFFF_FF9C, 32'h0000_0007, sc, sd, sad, mr);
        n_checks++; if (lo !== 32'hFFFF_FFF2) $display("FAIL prio_lo actual=%h expected=fffffff2", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL prio_hi actual=%h expected=fffffffe", hi); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int cyc; bit seen;
        @(posedge clk); #1;
        choice_md   = MD_DIVU;
        choice_hilo = HL_MD;
        rs_data     = 32'd100;
        rt_data     = 32'd7;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL abort_stall_in_rst actual=%b expected=0", stall); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy actual=%b expected=0", busy); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL abort_hi actual=%h expected=00000000", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL abort_lo actual=%h expected=00000000", lo); else n_pass++;
        cyc  = stall ? 1 : 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (stall) cyc++;
        end
        @(posedge clk); #1;
        choice_md   = 4'd0;
        choice_hilo = HL_NONE;
        @(negedge clk);
        n_checks++; if (seen !== 1'b1) $display("FAIL reissue_done actual=%b expected=1", seen); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL reissue_stall_cycles actual=%0d expected=33", cyc); else n_pass++;
        n_checks++; if (lo !== 32'd14) $display("FAIL reissue_lo actual=%h expected=0000000e", lo); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL reissue_hi actual=%h expected=00000002", hi); else n_pass++;
        $display("txn divu reissue after reset stall_cycles=%0d hi=%h lo=%h", cyc, hi, lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_multu();
        test_div_signed();
        test_div_boundary();
        test_mul();
        test_mthi_mfhi();
        test_priority();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
